// File: rtl/pc_seq_if.sv
// Fetch-side bundle between the PC sequencer and its surroundings:
// pc register, instruction memory, hazard unit and redirect sources.
interface pc_seq_if;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        fetch_req;
  logic        fetch_gnt;
  logic        stall;
  logic        br_valid;
  logic [31:0] br_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        halt_req;
  logic        resume;
  logic        flush;
  logic        halted;

  modport master (
    output pc_q, fetch_gnt, stall,
    output br_valid, br_target,
    output trap_valid, trap_target,
    output halt_req, resume,
    input  pc_d, fetch_req, flush, halted
  );

  modport slave (
    input  pc_q, fetch_gnt, stall,
    input  br_valid, br_target,
    input  trap_valid, trap_target,
    input  halt_req, resume,
    output pc_d, fetch_req, flush, halted
  );
endinterface

// File: rtl/pc_seq.sv
// Next-PC sequencer: BOOT/RUN/HALT control, redirect priority and
// a one-entry pending redirect held while fetch cannot advance.
module pc_seq #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic   clk,
  input logic   rst_n,
  pc_seq_if.slave bus
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic        pend_trap_q, pend_trap_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic [31:0] br_tgt;
  logic [31:0] trap_tgt;
  logic        advance;

  assign br_tgt   = bus.br_target & ~32'h3;
  assign trap_tgt = bus.trap_target & ~32'h3;
  assign advance  = (state_q == RUN) & bus.fetch_gnt & ~bus.stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BOOT;
      pend_valid_q  <= 1'b0;
      pend_trap_q   <= 1'b0;
      pend_target_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pend_valid_q  <= pend_valid_d;
      pend_trap_q   <= pend_trap_d;
      pend_target_q <= pend_target_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (bus.halt_req) state_d = HALT;
      HALT:    if (bus.resume) state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  // A queued trap is never displaced by a later branch.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_trap_d   = pend_trap_q;
    pend_target_d = pend_target_q;
    if (advance) begin
      pend_valid_d = 1'b0;
      pend_trap_d  = 1'b0;
    end else if (bus.trap_valid) begin
      pend_valid_d  = 1'b1;
      pend_trap_d   = 1'b1;
      pend_target_d = trap_tgt;
    end else if (bus.br_valid &&
                 !(pend_valid_q && pend_trap_q)) begin
      pend_valid_d  = 1'b1;
      pend_trap_d   = 1'b0;
      pend_target_d = br_tgt;
    end
  end

  always_comb begin
    bus.pc_d      = bus.pc_q;
    bus.fetch_req = 1'b0;
    bus.flush     = 1'b0;
    bus.halted    = 1'b0;
    unique case (state_q)
      BOOT: bus.pc_d = RESET_VECTOR;
      RUN: begin
        bus.fetch_req = 1'b1;
        if (advance) begin
          bus.flush = 1'b1;
          if (bus.trap_valid)
            bus.pc_d = trap_tgt;
          else if (bus.br_valid)
            bus.pc_d = br_tgt;
          else if (pend_valid_q)
            bus.pc_d = pend_target_q;
          else begin
            bus.pc_d  = bus.pc_q + 32'd4;
            bus.flush = 1'b0;
          end
        end
      end
      HALT: bus.halted = 1'b1;
      default: bus.pc_d = RESET_VECTOR;
    endcase
  end

endmodule

// File: tb/tb_pc_seq.sv
// Directed bench for pc_seq; the bench plays the external pc
// register by loading pc_q with hand-computed values each cycle.
module tb_pc_seq;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;

  pc_seq_if bus ();

  pc_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic adv_to(input logic [31:0] pcq);
    @(posedge clk);
    #1;
    bus.pc_q       = pcq;
    bus.br_valid   = 1'b0;
    bus.trap_valid = 1'b0;
    bus.halt_req   = 1'b0;
    bus.resume     = 1'b0;
  endtask

  task automatic chk_out(input string tag,
                         input logic [31:0] pcd,
                         input logic fr,
                         input logic fl,
                         input logic hl);
    chk({tag, ".pc_d"}, bus.pc_d, pcd);
    chk({tag, ".fetch_req"}, {31'h0, bus.fetch_req}, {31'h0, fr});
    chk({tag, ".flush"}, {31'h0, bus.flush}, {31'h0, fl});
    chk({tag, ".halted"}, {31'h0, bus.halted}, {31'h0, hl});
  endtask

  initial begin
    n_chk           = 0;
    n_err           = 0;
    rst_n           = 1'b0;
    bus.pc_q        = 32'h0000_0123;
    bus.fetch_gnt   = 1'b1;
    bus.stall       = 1'b0;
    bus.br_valid    = 1'b0;
    bus.br_target   = 32'h0;
    bus.trap_valid  = 1'b0;
    bus.trap_target = 32'h0;
    bus.halt_req    = 1'b0;
    bus.resume      = 1'b0;

    @(negedge clk);
    chk_out("reset", 32'h0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    chk_out("boot", 32'h0, 1'b0, 1'b0, 1'b0);

    // Sequential run from the reset vector
    adv_to(32'h0);
    @(negedge clk);
    chk_out("seq0", 32'h4, 1'b1, 1'b0, 1'b0);
    adv_to(32'h4);
    @(negedge clk);
    chk_out("seq4", 32'h8, 1'b1, 1'b0, 1'b0);
    adv_to(32'h8);
    @(negedge clk);
    chk_out("seq8", 32'hC, 1'b1, 1'b0, 1'b0);
    adv_to(32'hC);
    @(negedge clk);
    chk_out("seqC", 32'h10, 1'b1, 1'b0, 1'b0);

    // Direct branch with misaligned target
    adv_to(32'h8);
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h8000_0002;
    @(negedge clk);
    chk_out("br_dir", 32'h8000_0000, 1'b1, 1'b1, 1'b0);
    adv_to(32'h8000_0000);
    @(negedge clk);
    chk_out("br_next", 32'h8000_0004, 1'b1, 1'b0, 1'b0);

    // Branch captured under stall
    adv_to(32'h10);
    bus.stall     = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h40;
    @(negedge clk);
    chk_out("stall1", 32'h10, 1'b1, 1'b0, 1'b0);
    adv_to(32'h10);
    @(negedge clk);
    chk_out("stall2", 32'h10, 1'b1, 1'b0, 1'b0);
    adv_to(32'h10);
    @(negedge clk);
    chk_out("stall3", 32'h10, 1'b1, 1'b0, 1'b0);
    adv_to(32'h10);
    bus.stall = 1'b0;
    @(negedge clk);
    chk_out("pend_br", 32'h40, 1'b1, 1'b1, 1'b0);
    adv_to(32'h40);
    @(negedge clk);
    chk_out("pend_clr", 32'h44, 1'b1, 1'b0, 1'b0);

    // Trap beats branch; later branch dropped behind pending trap
    adv_to(32'h44);
    bus.stall       = 1'b1;
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h100;
    bus.br_valid    = 1'b1;
    bus.br_target   = 32'h40;
    @(negedge clk);
    chk_out("tb_cap", 32'h44, 1'b1, 1'b0, 1'b0);
    adv_to(32'h44);
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h60;
    @(negedge clk);
    chk_out("br_drop", 32'h44, 1'b1, 1'b0, 1'b0);
    adv_to(32'h44);
    bus.stall = 1'b0;
    @(negedge clk);
    chk_out("pend_trap", 32'h100, 1'b1, 1'b1, 1'b0);
    adv_to(32'h100);
    @(negedge clk);
    chk_out("trap_clr", 32'h104, 1'b1, 1'b0, 1'b0);

    // No grant blocks advance
    adv_to(32'h104);
    bus.fetch_gnt = 1'b0;
    @(negedge clk);
    chk_out("no_gnt", 32'h104, 1'b1, 1'b0, 1'b0);
    adv_to(32'h104);
    bus.fetch_gnt = 1'b1;
    @(negedge clk);
    chk_out("gnt", 32'h108, 1'b1, 1'b0, 1'b0);

    // Pending branch superseded by a direct trap, then cleared
    adv_to(32'h108);
    bus.stall     = 1'b1;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h300;
    @(negedge clk);
    chk_out("pb_cap", 32'h108, 1'b1, 1'b0, 1'b0);
    adv_to(32'h108);
    bus.stall       = 1'b0;
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h403;
    @(negedge clk);
    chk_out("trap_dir", 32'h400, 1'b1, 1'b1, 1'b0);
    adv_to(32'h400);
    @(negedge clk);
    chk_out("dir_clr", 32'h404, 1'b1, 1'b0, 1'b0);

    // Wrap of sequential increment
    adv_to(32'hFFFF_FFFC);
    @(negedge clk);
    chk_out("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

    // Halt with advance completing first
    adv_to(32'h0);
    bus.halt_req = 1'b1;
    @(negedge clk);
    chk_out("halt_req", 32'h4, 1'b1, 1'b0, 1'b0);
    adv_to(32'h4);
    bus.halt_req = 1'b1;
    @(negedge clk);
    chk_out("halt1", 32'h4, 1'b0, 1'b0, 1'b1);
    adv_to(32'h4);
    bus.trap_valid  = 1'b1;
    bus.trap_target = 32'h200;
    @(negedge clk);
    chk_out("halt_trap", 32'h4, 1'b0, 1'b0, 1'b1);
    adv_to(32'h4);
    bus.resume = 1'b1;
    @(negedge clk);
    chk_out("resume", 32'h4, 1'b0, 1'b0, 1'b1);
    adv_to(32'h4);
    @(negedge clk);
    chk_out("res_trap", 32'h200, 1'b1, 1'b1, 1'b0);
    adv_to(32'h200);
    @(negedge clk);
    chk_out("res_clr", 32'h204, 1'b1, 1'b0, 1'b0);

    // Halt without advance, capture a branch, then reset
    adv_to(32'h204);
    bus.stall    = 1'b1;
    bus.halt_req = 1'b1;
    @(negedge clk);
    chk_out("halt_stl", 32'h204, 1'b1, 1'b0, 1'b0);
    adv_to(32'h204);
    bus.stall     = 1'b0;
    bus.br_valid  = 1'b1;
    bus.br_target = 32'h500;
    @(negedge clk);
    chk_out("halt2", 32'h204, 1'b0, 1'b0, 1'b1);
    bus.br_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk_out("rst_halt", 32'h0, 1'b0, 1'b0, 1'b0);
    #1;
    rst_n = 1'b1;
    #1;
    chk_out("boot2", 32'h0, 1'b0, 1'b0, 1'b0);
    adv_to(32'h0);
    @(negedge clk);
    chk_out("post_rst", 32'h4, 1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
